// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake plus shared fifo write port seen by fifo_write_arbiter.
// The arbiter binds to the slave modport; producers and the fifo sit on master.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) ();
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_write_en;
  logic                          fifo_full;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, grant, fifo_data_in, fifo_write_en
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, grant, fifo_data_in, fifo_write_en
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port, with burst ownership of up to MAX_BURST beats.
// Optional per-requester saturating beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  MAX_BURST  = 4,
  parameter int  STAT_WIDTH = 16,
  localparam int SEL_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_write_arbiter_if.slave   bus,
  input  logic [SEL_W-1:0]      stat_sel,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_count
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [SEL_W-1:0]   winner;
  logic [SEL_W-1:0]   sel;
  logic               found;
  logic [NUM_REQ-1:0] accept;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[SEL_W-1:0];
  endfunction

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[wrap_add(rr_ptr, k)]) begin
        winner = wrap_add(rr_ptr, k);
        found  = 1'b1;
      end
    end
  end

  // A burst owner keeps the grant even while stalled on full or after dropping valid.
  always_comb begin
    bus.grant     = '0;
    bus.req_ready = '0;
    sel           = winner;
    if (!rst) begin
      if (state == BURST) begin
        sel                  = owner;
        bus.grant[owner]     = 1'b1;
        bus.req_ready[owner] = !bus.fifo_full;
      end else if (found && !bus.fifo_full) begin
        bus.grant[winner]     = 1'b1;
        bus.req_ready[winner] = 1'b1;
      end
    end
  end

  assign accept            = bus.req_valid & bus.req_ready;
  assign bus.fifo_write_en = |accept;
  assign bus.fifo_data_in  = (|bus.grant) ? bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH]
                                          : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !bus.fifo_full) begin
            if (MAX_BURST == 1) begin
              rr_ptr <= wrap_add(winner, 1);
            end else begin
              state    <= BURST;
              owner    <= winner;
              beat_cnt <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          if (!bus.req_valid[owner]) begin
            state  <= IDLE;
            rr_ptr <= wrap_add(owner, 1);
          end else if (!bus.fifo_full) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
              state  <= IDLE;
              rr_ptr <= wrap_add(owner, 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

  // NOTE: the counter array is software-visible, so it is cleared by reset rather than left undefined.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || stat_clr) begin
        stat_q[i] <= '0;
      end else if (accept[i] && (stat_q[i] != '1)) begin
        stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_count = stat_q[stat_sel];
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_count  = '0;
`endif

endmodule
